// File: rtl/mini_alu_seq.sv
// Sequenced mini ALU: programs are loaded into an internal memory and run line by line against a register file.
// Optional feature macro: MINI_ALU_MUL_EN (opcode 111 = MUL; when undefined it flags ILLEGAL and skips the line).
module mini_alu_seq #(
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 16,
  parameter int MAX_LINES = 16,
  parameter int RA_W      = $clog2(NUM_REGS),
  parameter int PA_W      = $clog2(MAX_LINES),
  parameter int LINE_W    = 3 + RA_W + 2 * (DATA_W + 1)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       LOAD_VALID,
  input  logic [PA_W-1:0]            LOAD_ADDR,
  input  logic [LINE_W-1:0]          LOAD_DATA,
  input  logic [PA_W:0]              PROGRAM_LINES_COUNT,
  input  logic                       START,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       CARRY,
  output logic                       ZERO,
  output logic                       ILLEGAL,
  output logic [NUM_REGS*DATA_W-1:0] REGISTER_OUTPUT_DATA_BUS
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_FIN
  } state_t;

  localparam logic [2:0]    OP_ADD = 3'b000;
  localparam logic [2:0]    OP_SUB = 3'b001;
  localparam logic [2:0]    OP_AND = 3'b010;
  localparam logic [2:0]    OP_OR  = 3'b011;
  localparam logic [2:0]    OP_XOR = 3'b100;
  localparam logic [2:0]    OP_SHL = 3'b101;
  localparam logic [2:0]    OP_SHR = 3'b110;
  localparam logic [PA_W:0] LP_MAX_LINES = (PA_W + 1)'(MAX_LINES);
  localparam logic [DATA_W:0] LP_DATA_W  = (DATA_W + 1)'(DATA_W);

  state_t              r_state;
  state_t              w_next_state;
  logic [PA_W-1:0]     r_pc;
  logic [PA_W:0]       r_cnt;
  logic [PA_W:0]       w_cnt_clip;
  logic [LINE_W-1:0]   r_mem [MAX_LINES];
  logic [LINE_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic                r_carry;
  logic                r_zero;
  logic                r_illegal;

  logic [2:0]          w_opc;
  logic [RA_W-1:0]     w_dst;
  logic                w_aimm;
  logic                w_bimm;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_a_op;
  logic [DATA_W-1:0]   w_b_op;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic                w_shift_big;
  logic [DATA_W-1:0]   w_res;
  logic                w_wr;
  logic                w_carry_upd;
  logic                w_carry_new;
  logic                w_illegal_op;
  logic                w_last;
  logic                w_busy;

  assign {w_opc, w_dst, w_aimm, w_a, w_bimm, w_b} = r_ir;

  assign w_a_op      = w_aimm ? w_a : r_regs[w_a[RA_W-1:0]];
  assign w_b_op      = w_bimm ? w_b : r_regs[w_b[RA_W-1:0]];
  assign w_sum       = {1'b0, w_a_op} + {1'b0, w_b_op};
  assign w_diff      = {1'b0, w_a_op} - {1'b0, w_b_op};
  assign w_shift_big = ({1'b0, w_b_op} >= LP_DATA_W);
  assign w_cnt_clip  = (PROGRAM_LINES_COUNT > LP_MAX_LINES) ? LP_MAX_LINES : PROGRAM_LINES_COUNT;
  assign w_last      = ({1'b0, r_pc} == (r_cnt - 1'b1));
  assign w_busy      = (r_state == ST_FETCH) || (r_state == ST_EXEC);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (START) w_next_state = (w_cnt_clip == '0) ? ST_FIN : ST_FETCH;
      ST_FETCH: w_next_state = ST_EXEC;
      ST_EXEC:  w_next_state = w_last ? ST_FIN : ST_FETCH;
      ST_FIN:   w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_res        = '0;
    w_wr         = 1'b1;
    w_carry_upd  = 1'b0;
    w_carry_new  = r_carry;
    w_illegal_op = 1'b0;
    unique case (w_opc)
      OP_ADD: begin
        w_res       = w_sum[DATA_W-1:0];
        w_carry_upd = 1'b1;
        w_carry_new = w_sum[DATA_W];
      end
      OP_SUB: begin
        w_res       = w_diff[DATA_W-1:0];
        w_carry_upd = 1'b1;
        w_carry_new = w_diff[DATA_W];
      end
      OP_AND:  w_res = w_a_op & w_b_op;
      OP_OR:   w_res = w_a_op | w_b_op;
      OP_XOR:  w_res = w_a_op ^ w_b_op;
      OP_SHL:  w_res = w_shift_big ? '0 : (w_a_op << w_b_op);
      OP_SHR:  w_res = w_shift_big ? '0 : (w_a_op >> w_b_op);
      default: begin
`ifdef MINI_ALU_MUL_EN
        w_res = w_a_op * w_b_op;
`else
        w_wr         = 1'b0;
        w_illegal_op = 1'b1;
`endif
      end
    endcase
  end

  // NOTE: program memory has no reset; it is plain storage and must be reloaded after RESET.
  always_ff @(posedge CLK) begin
    if (LOAD_VALID && !w_busy) begin
      r_mem[LOAD_ADDR] <= LOAD_DATA;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pc      <= '0;
      r_cnt     <= '0;
      r_ir      <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_cnt <= w_cnt_clip;
            r_pc  <= '0;
          end
        end
        ST_FETCH: r_ir <= r_mem[r_pc];
        ST_EXEC: begin
          if (w_wr) begin
            r_regs[w_dst] <= w_res;
            r_zero        <= (w_res == '0);
          end
          if (w_carry_upd)  r_carry   <= w_carry_new;
          if (w_illegal_op) r_illegal <= 1'b1;
          if (!w_last)      r_pc      <= r_pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    REGISTER_OUTPUT_DATA_BUS = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      REGISTER_OUTPUT_DATA_BUS[i*DATA_W +: DATA_W] = r_regs[i];
    end
  end

  assign BUSY    = w_busy;
  assign DONE    = (r_state == ST_FIN);
  assign CARRY   = r_carry;
  assign ZERO    = r_zero;
  assign ILLEGAL = r_illegal;

endmodule

// File: doc/mini_alu_seq.md
Name: mini_alu_seq

Overview:
Parametrised successor to the flat-bus FU. Program lines are loaded one at a time into an internal program memory through a write port. After START, the block executes them in order against an internal register file. Each line does one ALU op on register or immediate operands and writes one destination register. The block reports BUSY/DONE and carry/zero status, and exposes the whole register file as a flat output bus to the surrounding MiniALU datapath.

Parameters:
DATA_W, 8, width of each register and of each immediate.
NUM_REGS, 16, number of registers in the register file (power of 2).
MAX_LINES, 16, depth of the program memory (power of 2).
RA_W, $clog2(NUM_REGS), register index width (derived).
PA_W, $clog2(MAX_LINES), program address width (derived).
LINE_W, 3+RA_W+2*(DATA_W+1), program line width (derived).

Ports:
CLK  in  1  clock; all state changes on the rising edge.
RESET  in  1  asynchronous reset, active-high.
LOAD_VALID  in  1  write LOAD_DATA into program memory at LOAD_ADDR.
LOAD_ADDR  in  PA_W  program memory write address.
LOAD_DATA  in  LINE_W  program line {OPC[2:0], DST[RA_W-1:0], AIMM, A[DATA_W-1:0], BIMM, B[DATA_W-1:0]}.
PROGRAM_LINES_COUNT  in  PA_W+1  number of lines to run; sampled on START.
START  in  1  one-cycle pulse that begins execution.
BUSY  out  1  high while executing.
DONE  out  1  one-cycle pulse when the run ends.
CARRY  out  1  carry/borrow of the last ADD/SUB.
ZERO  out  1  high when the last written result was 0.
ILLEGAL  out  1  sticky; an unsupported opcode was executed.
REGISTER_OUTPUT_DATA_BUS  out  NUM_REGS*DATA_W  register i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset (asynchronous): state IDLE; PC=0; all registers 0; BUSY, DONE, CARRY, ZERO, ILLEGAL all 0. Program memory is not reset and must be reloaded after reset.
- Operands: if AIMM=1 the operand is A; otherwise it is reg[A[RA_W-1:0]]. B/BIMM work the same way.
- Opcodes: 000 ADD; 001 SUB (A-B); 010 AND; 011 OR; 100 XOR; 101 SHL A by B; 110 SHR (logical) A by B; 111 see Optional Feature.
- Shifts: if B >= DATA_W the result is 0.
- CARRY: updated only by ADD (carry out) and SUB (1 = borrow).
- ZERO: updated on every register write.
- Result width: all results are truncated to DATA_W.
- FSM states: IDLE, FETCH, EXEC, FIN.
- IDLE + START: latch cnt = min(PROGRAM_LINES_COUNT, MAX_LINES); PC=0; BUSY=1. If cnt==0 go to FIN, else go to FETCH.
- FETCH: register mem[PC] into the instruction register. Takes 1 cycle.
- EXEC: read operands, compute, write reg[DST] at the end of the cycle. If PC==cnt-1 go to FIN, else PC++ and go to FETCH.
- FIN: DONE=1 for exactly this cycle, BUSY=0, then IDLE.
- Latency: a run of N lines takes 2N cycles of BUSY; DONE appears on cycle 2N+1 after START. A run with cnt==0 gives DONE 1 cycle after START.
- Hazards: each write completes before the next FETCH, so a line always sees the previous line's result. DST may equal a source register.
- START while BUSY: ignored.
- LOAD_VALID while BUSY: ignored (no write). LOAD_VALID and START in the same cycle from IDLE: the load takes effect and execution starts; the loaded line is visible to the run.
- RESET mid-run: immediate return to IDLE, registers cleared, no DONE pulse.
- Register bus: continuously reflects the register file.

Optional Feature:
MINI_ALU_MUL_EN.
- Defined: opcode 111 = MUL, result = low DATA_W bits of A*B; CARRY is unchanged.
- Undefined: opcode 111 sets ILLEGAL=1 (sticky until reset), performs no register write, leaves CARRY/ZERO unchanged, and execution continues with the next line.

Test Plan:
1. Load L0 = ADD r2, imm 12, imm 6; START with count=1 -> BUSY for 2 cycles, DONE on cycle 3, r2=0x12, CARRY=0, ZERO=0.
2. Load L0 = ADD r1, imm 0xF0, imm 0x20; L1 = SUB r3, r1, imm 0x10; count=2 -> r1=0x10, r3=0x00, ZERO=1, CARRY=0, DONE at cycle 5.
3. Load L0 = SHL r5, imm 0x81, imm 1; L1 = SHR r6, imm 0x80, imm 9; count=2 -> r5=0x02, r6=0x00.
4. Load opcode 111 with A=imm 7, B=imm 9 into r7 -> with MINI_ALU_MUL_EN, r7=0x3F; without it, r7=0 and ILLEGAL=1.
5. Count=0 -> DONE 1 cycle after START, no register changes. Count=20 -> clipped to 16 lines, 32 BUSY cycles. START and LOAD pulsed while BUSY -> both ignored.
6. Start a 3-line run and assert RESET during the 2nd EXEC -> immediately BUSY=0, all registers 0, no DONE. A new load and START afterwards runs normally.
